// File: rtl/msfsm_tick_scheduler.sv
// Round-robin scheduler for the internal tick transitions of a set of Mealy MSFSMs.
// Optional stall watchdog enabled by defining MSFSM_SCHED_WDOG_EN.
module msfsm_tick_scheduler #(
    parameter int unsigned N_TICK      = 4,
    parameter int unsigned SETTLE      = 1,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              hold,
    input  logic [N_TICK-1:0] t_req,
    input  logic [N_TICK-1:0] t_mask,
    output logic [N_TICK-1:0] t_fire,
    output logic              busy,
    output logic [CNT_W-1:0]  fire_cnt,
    output logic              stall
);

    localparam int unsigned PTR_W = (N_TICK > 1) ? $clog2(N_TICK) : 1;
    localparam int unsigned SET_W = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRE   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  grant_q, grant_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [N_TICK-1:0] t_fire_q, t_fire_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  fire_cnt_q, fire_cnt_d;

    logic [N_TICK-1:0] elig_c;
    logic              pick_found_c;
    logic [PTR_W-1:0]  pick_idx_c;

    assign elig_c = t_req & ~t_mask;

    // First eligible index at or after the pointer, searching circularly.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_TICK-1:0] vec,
                                               input logic [PTR_W-1:0]  ptr);
        logic             found;
        logic [PTR_W-1:0] sel;
        logic [PTR_W-1:0] pos;
        int unsigned      idx;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < N_TICK; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_TICK) idx = idx - N_TICK;
            pos = PTR_W'(idx);
            if (!found && vec[pos]) begin
                found = 1'b1;
                sel   = pos;
            end
        end
        return {found, sel};
    endfunction

    assign {pick_found_c, pick_idx_c} = rr_pick(elig_c, rr_ptr_q);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        settle_cnt_d = settle_cnt_q;
        t_fire_d     = '0;
        fire_cnt_d   = fire_cnt_q;
        case (state_q)
            S_IDLE: begin
                // Pending environment changes (hold) take priority over ticks.
                if (en && !hold && pick_found_c) begin
                    t_fire_d = N_TICK'(1) << pick_idx_c;
                    grant_d  = pick_idx_c;
                    state_d  = S_FIRE;
                end
            end
            S_FIRE: begin
                rr_ptr_d     = (32'(grant_q) == N_TICK - 1) ? '0 : grant_q + PTR_W'(1);
                fire_cnt_d   = fire_cnt_q + CNT_W'(1);
                settle_cnt_d = SET_W'(SETTLE);
                state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                settle_cnt_d = settle_cnt_q - SET_W'(1);
                if (settle_cnt_q <= SET_W'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            settle_cnt_q <= '0;
            t_fire_q     <= '0;
            busy_q       <= 1'b0;
            fire_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            settle_cnt_q <= settle_cnt_d;
            t_fire_q     <= t_fire_d;
            busy_q       <= busy_d;
            fire_cnt_q   <= fire_cnt_d;
        end
    end

    assign t_fire   = t_fire_q;
    assign busy     = busy_q;
    assign fire_cnt = fire_cnt_q;

`ifdef MSFSM_SCHED_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            stall_q, stall_d;

    // Counts starved idle cycles; saturates at the threshold, stall is sticky.
    always_comb begin
        wdog_d  = '0;
        stall_d = stall_q;
        if (state_q == S_IDLE && en && !hold && elig_c == '0) begin
            wdog_d = wdog_q;
            if (32'(wdog_q) < WDOG_CYCLES) wdog_d = wdog_q + WD_W'(1);
        end
        if (32'(wdog_d) >= WDOG_CYCLES) stall_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

endmodule
